// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues single-outstanding imem reads at the current PC,
// queues returned words for decode, and computes the next PC for the PC register.
module fetch_unit #(
  parameter int width      = 32,
  parameter int inst_width = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [width-1:0]      pc,
  output logic [width-1:0]      addr,
  input  logic                  redirect_valid,
  input  logic [width-1:0]      redirect_target,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [width-1:0]      imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [inst_width-1:0] imem_resp_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [inst_width-1:0] inst_data,
  output logic [width-1:0]      inst_pc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [1:0]            count;
  logic [width-1:0]      pend_pc;
  logic [width-1:0]      q_pc   [2];
  logic [inst_width-1:0] q_data [2];

  logic hs;
  logic push;
  logic pop;

  assign imem_req_valid = (state == IDLE) && (count < 2'd2) && !redirect_valid && !rst;
  assign imem_req_addr  = pc;
  assign hs             = imem_req_valid && imem_req_ready;

  // A redirect in the same cycle as a response kills the response.
  assign push       = (state == WAIT) && imem_resp_valid && !redirect_valid;
  assign inst_valid = (count != 2'd0) && !redirect_valid;
  assign pop        = inst_valid && inst_ready;
  assign inst_data  = q_data[0];
  assign inst_pc    = q_pc[0];

  always_comb begin
    addr = pc;
    if (redirect_valid) begin
      addr = redirect_target;
    end else if (hs) begin
      addr = pc + width'(4);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hs) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid)     state_nxt = IDLE;
        else if (redirect_valid) state_nxt = DROP;
      end
      DROP: begin
        if (imem_resp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Entry 0 is always the head; it keeps its value after the last pop so the
  // decode-facing outputs hold steady while the queue is empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      pend_pc   <= '0;
      q_pc[0]   <= '0;
      q_pc[1]   <= '0;
      q_data[0] <= '0;
      q_data[1] <= '0;
    end else begin
      if (hs) pend_pc <= pc;

      if (redirect_valid) begin
        count <= 2'd0;
      end else if (push && !pop) begin
        count <= count + 2'd1;
      end else if (pop && !push) begin
        count <= count - 2'd1;
      end

      if (push) begin
        if (count == 2'd0 || (count == 2'd1 && pop)) begin
          q_pc[0]   <= pend_pc;
          q_data[0] <= imem_resp_data;
        end else if (count == 2'd2 && pop) begin
          q_pc[0]   <= q_pc[1];
          q_data[0] <= q_data[1];
          q_pc[1]   <= pend_pc;
          q_data[1] <= imem_resp_data;
        end else begin
          q_pc[1]   <= pend_pc;
          q_data[1] <= imem_resp_data;
        end
      end else if (pop && count == 2'd2) begin
        q_pc[0]   <= q_pc[1];
        q_data[0] <= q_data[1];
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; the bench models the PC register (pc <= addr).
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] addr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int tests = 0;
  int fails = 0;

  fetch_unit #(.width(32), .inst_width(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .addr            (addr),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (rst) pc <= 32'h0;
    else     pc <= addr;
  end

  always @(negedge clk) begin
    if (dut.count > 2'd2) begin
      fails++;
      $display("FAIL count_bound: count=%0d, must be <= 2", dut.count);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] d);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = d;
    cyc();
    imem_resp_valid = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    redirect_valid  = 1'b1;
    redirect_target = t;
    cyc();
    redirect_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    cyc();
    #1;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid); end
    tests++; if (addr !== 32'h0) begin fails++; $display("FAIL rst_addr: got %h want 00000000", addr); end
    tests++; if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin fails++; $display("FAIL rst_head: data %h pc %h want 0/0", inst_data, inst_pc); end
    rst = 1'b0;
    #1;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL rst_release_req: valid %b addr %h want 1/00000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_sequential();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    #1;
    tests++; if (addr !== 32'h4) begin fails++; $display("FAIL seq_accept_addr: got %h want 00000004", addr); end
    cyc();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h00500093;
    #1;
    tests++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin fails++; $display("FAIL seq_wait: req_valid %b inst_valid %b want 0/0", imem_req_valid, inst_valid); end
    cyc();
    imem_resp_valid = 1'b0;
    #1;
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h00500093) begin fails++; $display("FAIL seq_deliver: valid %b pc %h data %h want 1/00000000/00500093", inst_valid, inst_pc, inst_data); end
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin fails++; $display("FAIL seq_next_req: valid %b addr %h want 1/00000004", imem_req_valid, imem_req_addr); end
    cyc();
    #1;
    tests++; if (inst_valid !== 1'b0 || inst_data !== 32'h00500093) begin fails++; $display("FAIL seq_hold: valid %b data %h want 0/00500093", inst_valid, inst_data); end
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0;
    redirect_to(32'h0);
    fetch(32'h11111111);
    fetch(32'h22222222);
    #1;
    tests++; if (imem_req_valid !== 1'b0 || addr !== 32'h8) begin fails++; $display("FAIL bp_full_hold: req_valid %b addr %h want 0/00000008", imem_req_valid, addr); end
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst_data !== 32'h11111111) begin fails++; $display("FAIL bp_head: valid %b pc %h data %h want 1/00000000/11111111", inst_valid, inst_pc, inst_data); end
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    #1;
    tests++; if (inst_pc !== 32'h4 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8 || addr !== 32'hC) begin fails++; $display("FAIL bp_release: head_pc %h req_valid %b req_addr %h addr %h want 00000004/1/00000008/0000000c", inst_pc, imem_req_valid, imem_req_addr, addr); end
    cyc();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h33333333;
    cyc();
    imem_resp_valid = 1'b0;
    inst_ready      = 1'b1;
    #1;
    tests++; if (inst_pc !== 32'h4 || inst_data !== 32'h22222222) begin fails++; $display("FAIL bp_order0: pc %h data %h want 00000004/22222222", inst_pc, inst_data); end
    cyc();
    #1;
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_data !== 32'h33333333) begin fails++; $display("FAIL bp_order1: valid %b pc %h data %h want 1/00000008/33333333", inst_valid, inst_pc, inst_data); end
    cyc();
    inst_ready = 1'b0;
    #1;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got %b want 0", inst_valid); end
  endtask

  task automatic test_redirect();
    fetch(32'h44444444);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h10000000;
    #1;
    tests++; if (inst_valid !== 1'b0 || addr !== 32'h10000000 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL redir_cycle: inst_valid %b addr %h req_valid %b want 0/10000000/0", inst_valid, addr, imem_req_valid); end
    cyc();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEADBEEF;
    #1;
    tests++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL redir_drop_state: inst_valid %b req_valid %b want 0/0", inst_valid, imem_req_valid); end
    cyc();
    imem_resp_valid = 1'b0;
    #1;
    tests++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h10000000) begin fails++; $display("FAIL redir_new_req: inst_valid %b req_valid %b addr %h want 0/1/10000000", inst_valid, imem_req_valid, imem_req_addr); end
    fetch(32'h55555555);
    #1;
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10000000 || inst_data !== 32'h55555555) begin fails++; $display("FAIL redir_first_inst: valid %b pc %h data %h want 1/10000000/55555555", inst_valid, inst_pc, inst_data); end
    inst_ready = 1'b1;
    cyc();
    inst_ready = 1'b0;
    #1;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL redir_pop: got %b want 0", inst_valid); end
  endtask

  task automatic test_redirect_resp();
    fetch(32'h66666666);
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h00000200;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h77777777;
    #1;
    tests++; if (inst_valid !== 1'b0 || addr !== 32'h200) begin fails++; $display("FAIL rr_cycle: inst_valid %b addr %h want 0/00000200", inst_valid, addr); end
    cyc();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    #1;
    tests++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin fails++; $display("FAIL rr_idle: inst_valid %b req_valid %b addr %h want 0/1/00000200", inst_valid, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_wrap();
    redirect_to(32'hFFFFFFF8);
    fetch(32'h99999999);
    imem_req_ready = 1'b1;
    #1;
    tests++; if (addr !== 32'h0 || imem_req_addr !== 32'hFFFFFFFC) begin fails++; $display("FAIL wrap_addr: addr %h req_addr %h want 00000000/fffffffc", addr, imem_req_addr); end
    cyc();
    imem_req_ready = 1'b0;
    rst            = 1'b1;
    #1;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL wrap_rst_req: got %b want 0", imem_req_valid); end
    cyc();
    rst             = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hAAAAAAAA;
    #1;
    tests++; if (inst_valid !== 1'b0 || inst_data !== 32'h0 || inst_pc !== 32'h0) begin fails++; $display("FAIL wrap_rst_queue: valid %b data %h pc %h want 0/0/0", inst_valid, inst_data, inst_pc); end
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL wrap_rst_idle: valid %b addr %h want 1/00000000", imem_req_valid, imem_req_addr); end
    cyc();
    imem_resp_valid = 1'b0;
    #1;
    tests++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1) begin fails++; $display("FAIL wrap_resp_ignored: inst_valid %b req_valid %b want 0/1", inst_valid, imem_req_valid); end
  endtask

  initial begin
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    inst_ready      = 1'b0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_redirect_resp();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
